// File: rtl/iis_tx_multiformat_if.sv
// iis_tx_multiformat_if: producer-side write bus of the audio transmitter
// Signals: Data_In {L,R} words, Write_Enable push strobe, Write_Allow and wrusedw back-pressure/occupancy
interface iis_tx_multiformat_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
);
   logic [2*DATA_WIDTH-1:0] Data_In;
   logic                    Write_Enable;
   logic                    Write_Allow;
   logic [ADDR_WIDTH:0]     wrusedw;
   modport master (output Data_In, Write_Enable, input Write_Allow, wrusedw);
   modport slave (input Data_In, Write_Enable, output Write_Allow, wrusedw);
endinterface

// File: rtl/iis_tx_multiformat.sv
// iis_tx_multiformat: FIFO-buffered stereo PCM serialiser (I2S/LJ/DSP-A/DSP-B) slaved to codec BCLK/LRC
// Ports: Write_Clk sole clock (>= 4x BCLK); rst_n async active-low; Mode 00 I2S, 01 LJ, 10 DSP-A, 11 DSP-B;
//        IIS_BCLK/IIS_DACLRC codec clocks in; IIS_DACDAT serial data out, MSB first;
//        Underrun/Overflow sticky flags, Flag_Clr clears them;
//        bus (slave): Data_In, Write_Enable in; Write_Allow, wrusedw out.
module iis_tx_multiformat #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9,
   parameter int ALLOW_ON   = 2 ** (ADDR_WIDTH - 1),
   parameter int ALLOW_OFF  = 2 ** ADDR_WIDTH - 4
) (
   input  logic                    Write_Clk,
   input  logic                    rst_n,
   input  logic [1:0]              Mode,
   input  logic                    IIS_BCLK,
   input  logic                    IIS_DACLRC,
   output logic                    IIS_DACDAT,
   output logic                    Underrun,
   output logic                    Overflow,
   input  logic                    Flag_Clr,
   iis_tx_multiformat_if.slave     bus
);
   localparam int W2  = 2 * DATA_WIDTH;
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam int CW  = $clog2(W2);
   localparam logic [ADDR_WIDTH:0] DEPTH = AW1'(2 ** ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] ON    = AW1'(ALLOW_ON);
   localparam logic [ADDR_WIDTH:0] OFF   = AW1'(ALLOW_OFF);
   localparam logic [CW-1:0]       LEN_S = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]       LEN_D = CW'(W2 - 1);

   typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} st_t;
   st_t st;

   logic [W2-1:0]         mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] wp, rp;
   logic [ADDR_WIDTH:0]   used;
   logic [2:0]            bclk_q;
   logic [1:0]            lrc_q, mode_q;
   logic                  lrc_s, lrc_v, pend, dout, wa, ur, ov;
   logic [W2-1:0]         fr, sh;
   logic [CW-1:0]         cnt;
   logic                  rise_evt, fall_evt, lrc_chg, frame_start, r_start, full, empty, push, pop, dly;

   assign rise_evt    = bclk_q[1] & ~bclk_q[2];
   assign fall_evt    = ~bclk_q[1] & bclk_q[2];
   // lrc_v blocks the first LRC sample after reset from looking like a transition
   assign lrc_chg     = rise_evt & lrc_v & (lrc_q[1] != lrc_s);
   assign frame_start = lrc_chg & (lrc_q[1] == |Mode);
   // I2S right channel opens on LRC rise, LJ right channel on LRC fall; DSP has no separate R start
   assign r_start     = lrc_chg & ~mode_q[1] & (lrc_q[1] ^ mode_q[0]);
   assign full        = used == DEPTH;
   assign empty       = used == '0;
   assign push        = bus.Write_Enable & ~full;
   assign pop         = frame_start & ~empty;
   assign dly         = ~mode_q[0];
   assign IIS_DACDAT  = dout;
   assign Underrun    = ur;
   assign Overflow    = ov;
   assign bus.Write_Allow = wa;
   assign bus.wrusedw     = used;

   always_ff @(posedge Write_Clk)
      if (push) mem[wp] <= bus.Data_In;

   always_ff @(posedge Write_Clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_q <= '0;
         lrc_q  <= '0;
         lrc_s  <= 1'b0;
         lrc_v  <= 1'b0;
         wp     <= '0;
         rp     <= '0;
         used   <= '0;
         wa     <= 1'b0;
         ur     <= 1'b0;
         ov     <= 1'b0;
         mode_q <= '0;
         fr     <= '0;
         sh     <= '0;
         cnt    <= '0;
         pend   <= 1'b0;
         dout   <= 1'b0;
         st     <= IDLE;
      end else begin
         bclk_q <= {bclk_q[1:0], IIS_BCLK};
         lrc_q  <= {lrc_q[0], IIS_DACLRC};
         if (rise_evt) begin
            lrc_s <= lrc_q[1];
            lrc_v <= 1'b1;
         end
         if (push) wp <= wp + ADDR_WIDTH'(1);
         if (pop) rp <= rp + ADDR_WIDTH'(1);
         used <= used + AW1'(push) - AW1'(pop);
         wa   <= wa ? (used < OFF) : (used < ON);
         ur   <= ~Flag_Clr & (ur | (frame_start & empty));
         ov   <= ~Flag_Clr & (ov | (bus.Write_Enable & full));
         // channel starts only arm the shifter; bits move on the following BCLK falls
         if (frame_start) begin
            mode_q <= Mode;
            fr     <= empty ? '0 : mem[rp];
            sh     <= empty ? '0 : mem[rp];
            pend   <= 1'b1;
         end else if (r_start) begin
            sh   <= {fr[DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
            pend <= 1'b1;
         end
         if (fall_evt) begin
            pend <= 1'b0;
            if ((pend && !dly) || (!pend && st == DELAY)) begin
               st   <= SHIFT;
               dout <= sh[W2-1];
               sh   <= sh << 1;
               cnt  <= mode_q[1] ? LEN_D : LEN_S;
            end else if (pend) begin
               st   <= DELAY;
               dout <= 1'b0;
            end else if (st == SHIFT && cnt != '0) begin
               dout <= sh[W2-1];
               sh   <= sh << 1;
               cnt  <= cnt - CW'(1);
            end else begin
               st   <= (st == SHIFT) ? PAD : st;
               dout <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_iis_tx_multiformat.sv
// tb_iis_tx_multiformat: directed scoreboard bench for iis_tx_multiformat acting as codec clock master
module tb_iis_tx_multiformat;
   logic       Write_Clk = 1'b0;
   logic       rst_n, IIS_BCLK, IIS_DACLRC, IIS_DACDAT, Underrun, Overflow, Flag_Clr;
   logic [1:0] Mode;
   int         checks = 0, failures = 0, h = 8;
   logic [31:0] model[$];
   logic        exp_q[$];
   logic        exp_ur = 1'b0, exp_ov = 1'b0;
   logic [31:0] w;

   iis_tx_multiformat_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

   iis_tx_multiformat dut (
      .Write_Clk(Write_Clk), .rst_n(rst_n), .Mode(Mode), .IIS_BCLK(IIS_BCLK),
      .IIS_DACLRC(IIS_DACLRC), .IIS_DACDAT(IIS_DACDAT), .Underrun(Underrun),
      .Overflow(Overflow), .Flag_Clr(Flag_Clr), .bus(bus)
   );

   always #5 Write_Clk = ~Write_Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [15:0] a;
      a = 16'(i);
      return {a ^ 16'hA5C3, a * 16'd3 + 16'd1};
   endfunction

   function automatic logic lrc_at(input logic [1:0] m, input int c, input int n);
      return m[1] ? (c == 0) : ((c < n / 2) ^ (m == 2'b00));
   endfunction

   // expected DACDAT seen at the BCLK rise of cycle c of an n-cycle frame carrying word x
   function automatic logic exp_bit(input logic [1:0] m, input logic [31:0] x, input int c, input int n);
      int j;
      logic [15:0] hw;
      if (m[1]) begin
         j = c - 1 - int'(!m[0]);
         return (j >= 0 && j < 32) ? x[31 - j] : 1'b0;
      end
      hw = (c < n / 2) ? x[31:16] : x[15:0];
      j = c - ((c < n / 2) ? 0 : n / 2) - 1 - int'(!m[0]);
      return (j >= 0 && j < 16) ? hw[15 - j] : 1'b0;
   endfunction

   task automatic wr(input logic [31:0] x);
      bus.Data_In = x;
      bus.Write_Enable = 1'b1;
      @(negedge Write_Clk);
      bus.Write_Enable = 1'b0;
      if (model.size() < 512) model.push_back(x);
      else exp_ov = 1'b1;
   endtask

   task automatic clr_flags();
      Flag_Clr = 1'b1;
      @(negedge Write_Clk);
      Flag_Clr = 1'b0;
      exp_ur = 1'b0;
      exp_ov = 1'b0;
   endtask

   task automatic bclk_cycle(input logic lrc, input logic cmp);
      IIS_BCLK = 1'b0;
      IIS_DACLRC = lrc;
      repeat (h) @(negedge Write_Clk);
      if (cmp) check("dacdat", 32'(IIS_DACDAT), 32'(exp_q.pop_front()));
      IIS_BCLK = 1'b1;
      repeat (h) @(negedge Write_Clk);
   endtask

   task automatic preamble(input logic lrc);
      repeat (4) bclk_cycle(lrc, 1'b0);
   endtask

   task automatic frame(input int n, input logic chk);
      logic [31:0] x;
      if (model.size() == 0) begin
         x = '0;
         exp_ur = 1'b1;
      end else x = model.pop_front();
      if (chk) for (int c = 1; c < n; c++) exp_q.push_back(exp_bit(Mode, x, c, n));
      for (int c = 0; c < n; c++) bclk_cycle(lrc_at(Mode, c, n), chk && c > 0);
   endtask

   initial begin
      rst_n = 1'b0;
      IIS_BCLK = 1'b0;
      IIS_DACLRC = 1'b0;
      Mode = 2'b00;
      Flag_Clr = 1'b0;
      bus.Write_Enable = 1'b0;
      bus.Data_In = '0;
      repeat (3) @(negedge Write_Clk);
      check("rst_dacdat", 32'(IIS_DACDAT), 32'd0);
      check("rst_allow", 32'(bus.Write_Allow), 32'd0);
      check("rst_used", 32'(bus.wrusedw), 32'd0);
      check("rst_underrun", 32'(Underrun), 32'd0);
      check("rst_overflow", 32'(Overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge Write_Clk);
      check("allow_after_rst", 32'(bus.Write_Allow), 32'd1);

      wr(32'hA5A5_0F0F);
      check("i2s_used1", 32'(bus.wrusedw), 32'd1);
      preamble(1'b1);
      frame(64, 1'b1);
      check("i2s_used0", 32'(bus.wrusedw), 32'd0);

      wr(32'h8001_8001);
      Mode = 2'b11;
      preamble(1'b0);
      frame(64, 1'b1);
      wr(32'h8001_8001);
      Mode = 2'b10;
      frame(64, 1'b1);

      wr(32'h1234_5678);
      wr(32'hCAFE_F00D);
      Mode = 2'b01;
      frame(64, 1'b1);
      frame(64, 1'b1);

      clr_flags();
      repeat (3) frame(64, 1'b1);
      check("underrun_set", 32'(Underrun), 32'(exp_ur));
      clr_flags();
      check("underrun_clr", 32'(Underrun), 32'(exp_ur));
      wr(32'h0F0F_F0F0);
      frame(64, 1'b1);
      check("underrun_stay0", 32'(Underrun), 32'(exp_ur));
      check("lj_used0", 32'(bus.wrusedw), 32'd0);

      Mode = 2'b11;
      for (int i = 0; i < 507; i++) wr(pat(i));
      check("hyst_used507", 32'(bus.wrusedw), 32'd507);
      check("hyst_allow507", 32'(bus.Write_Allow), 32'd1);
      wr(pat(507));
      check("hyst_used508", 32'(bus.wrusedw), 32'd508);
      @(negedge Write_Clk);
      check("hyst_allow_off", 32'(bus.Write_Allow), 32'd0);
      for (int i = 508; i < 512; i++) wr(pat(i));
      check("full_used", 32'(bus.wrusedw), 32'd512);
      check("full_no_ovf", 32'(Overflow), 32'(exp_ov));
      wr(32'hDEAD_BEEF);
      check("ovf_used", 32'(bus.wrusedw), 32'd512);
      check("ovf_set", 32'(Overflow), 32'(exp_ov));
      frame(64, 1'b1);
      h = 4;
      repeat (255) frame(4, 1'b0);
      check("drain_used256", 32'(bus.wrusedw), 32'd256);
      check("drain_allow256", 32'(bus.Write_Allow), 32'd0);
      frame(4, 1'b0);
      repeat (2) @(negedge Write_Clk);
      check("drain_used255", 32'(bus.wrusedw), 32'd255);
      check("drain_allow255", 32'(bus.Write_Allow), 32'd1);
      repeat (253) frame(4, 1'b0);
      h = 8;
      check("drain_used2", 32'(bus.wrusedw), 32'd2);
      repeat (3) frame(64, 1'b1);
      check("tail_underrun", 32'(Underrun), 32'(exp_ur));
      check("ovf_sticky", 32'(Overflow), 32'(exp_ov));

      wr(32'hFFFF_FFFF);
      wr(32'h1234_5678);
      w = model.pop_front();
      for (int c = 1; c <= 10; c++) exp_q.push_back(w[32 - c]);
      for (int c = 0; c <= 10; c++) bclk_cycle(c == 0, c > 0);
      rst_n = 1'b0;
      IIS_DACLRC = 1'b1;
      #1;
      check("midrst_dacdat", 32'(IIS_DACDAT), 32'd0);
      check("midrst_used", 32'(bus.wrusedw), 32'd0);
      model.delete();
      exp_ur = 1'b0;
      exp_ov = 1'b0;
      repeat (2) @(negedge Write_Clk);
      rst_n = 1'b1;
      wr(32'h0000_C003);
      for (int c = 0; c < 5; c++) begin
         exp_q.push_back(1'b0);
         bclk_cycle(1'b1, 1'b1);
      end
      check("post_rst_no_pop", 32'(bus.wrusedw), 32'd1);
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(1'b0);
         bclk_cycle(1'b0, 1'b1);
      end
      frame(64, 1'b1);
      check("post_rst_used0", 32'(bus.wrusedw), 32'd0);
      check("post_rst_underrun", 32'(Underrun), 32'(exp_ur));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
